// File: rtl/freq_divider_n.sv
// Programmable integer clock divider: divides clk_100Hz by N, with a registered
// square-wave output, a one-cycle tick per period and a wrapping period counter.
module freq_divider_n #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 100,
    parameter int TICKS_WIDTH = 8
) (
    input  logic                   clk_100Hz,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   load,
    input  logic [DIV_WIDTH-1:0]   div_ratio,
    output logic                   clk_out,
    output logic                   tick,
    output logic [DIV_WIDTH-1:0]   count,
    output logic [TICKS_WIDTH-1:0] ticks,
    output logic                   ratio_err
);

    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0]   shadow;
    logic [DIV_WIDTH-1:0]   n_active;
    logic [DIV_WIDTH-1:0]   shadow_nxt;
    logic [DIV_WIDTH-1:0]   n_active_nxt;
    logic [DIV_WIDTH-1:0]   count_nxt;
    logic [TICKS_WIDTH-1:0] ticks_nxt;
    logic                   tick_nxt;
    logic                   clk_out_nxt;
    logic                   load_ok;
    logic                   load_bad;
    logic                   wrap;

    always_comb begin
        load_ok      = load && (div_ratio != '0);
        load_bad     = load && (div_ratio == '0);
        shadow_nxt   = load_ok ? div_ratio : shadow;
        wrap         = (count == (n_active - DIV_WIDTH'(1)));

        count_nxt    = count;
        n_active_nxt = n_active;
        ticks_nxt    = ticks;
        tick_nxt     = 1'b0;
        clk_out_nxt  = clk_out;

        if (clear) begin
            // Clear uses shadow_nxt so a same-edge load takes effect at once.
            count_nxt    = '0;
            n_active_nxt = shadow_nxt;
        end else if (enable) begin
            if (wrap) begin
                count_nxt    = '0;
                tick_nxt     = 1'b1;
                ticks_nxt    = ticks + TICKS_WIDTH'(1);
                n_active_nxt = shadow;
            end else begin
                count_nxt    = count + DIV_WIDTH'(1);
            end
        end

        if (clear || enable) begin
            clk_out_nxt = (count_nxt >= (n_active_nxt >> 1));
        end
    end

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            shadow    <= RESET_DIV;
            n_active  <= RESET_DIV;
            count     <= '0;
            ticks     <= '0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            ratio_err <= 1'b0;
        end else begin
            shadow    <= shadow_nxt;
            n_active  <= n_active_nxt;
            count     <= count_nxt;
            ticks     <= ticks_nxt;
            tick      <= tick_nxt;
            clk_out   <= clk_out_nxt;
            ratio_err <= ratio_err | load_bad;
        end
    end

endmodule

// File: doc/freq_divider_n.md
FREQ_DIVIDER_N -- requirements
Module: freq_divider_n

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of divide-ratio and count registers.
REQ-002 Parameter DEFAULT_DIV, default 100: divide ratio after reset; legal range 2..2^DIV_WIDTH-1.
REQ-003 Parameter TICKS_WIDTH, default 8: width of wrap-event counter.
REQ-004 clk_100Hz  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = count advances; 0 = all state frozen.
REQ-007 clear  input  1  synchronous restart of the divide period.
REQ-008 load  input  1  one-cycle strobe; captures div_ratio into the shadow register.
REQ-009 div_ratio  input  DIV_WIDTH  requested divide ratio N.
REQ-010 clk_out  output  1  registered divided square wave, period N input cycles.
REQ-011 tick  output  1  registered one-cycle pulse, once per period.
REQ-012 count  output  DIV_WIDTH  current phase counter, 0..N_active-1.
REQ-013 ticks  output  TICKS_WIDTH  number of completed periods, wraps modulo 2^TICKS_WIDTH.
REQ-014 ratio_err  output  1  sticky flag: a load of 0 was attempted.

Function
REQ-015 The block SHALL hold two ratio registers: shadow (written by load) and N_active (in use).
- load with div_ratio != 0 SHALL write shadow on that edge.
- load with div_ratio == 0 SHALL leave shadow unchanged and set ratio_err.
REQ-016 On an edge with enable=1 and clear=0:
- if count == N_active-1: count <= 0, tick <= 1, ticks <= ticks+1, N_active <= shadow.
- otherwise: count <= count+1, tick <= 0.
REQ-017 N_active SHALL change only at a period wrap or on clear; changing shadow mid-period SHALL NOT shorten or lengthen the current period.
REQ-018 clk_out SHALL be registered and updated on the same edge as count, equal to 1 when the new count >= (new N_active >> 1), else 0.
- N=100: low for counts 0..49, high for 50..99.
- Odd N (e.g. 3): low for count 0, high for counts 1..2.
REQ-019 N_active == 1 (loaded ratio 1) SHALL give count fixed at 0, tick=1 every enabled cycle, clk_out=1 constantly.
REQ-020 clear=1 on an edge SHALL set count <= 0, tick <= 0 and N_active <= shadow, leave ticks unchanged, and set clk_out per REQ-018; clear SHALL take priority over enable.
REQ-021 clear and load on the same edge: the new div_ratio SHALL be captured and SHALL take effect immediately as N_active (load-to-clear bypass).
REQ-022 enable=0 without clear: count, N_active, ticks and clk_out SHALL hold, tick SHALL be 0, and load SHALL still update shadow.
REQ-023 ticks SHALL wrap from 2^TICKS_WIDTH-1 to 0 without any flag.
REQ-024 ratio_err SHALL clear only on reset.
REQ-025 Latency: tick is high in the cycle immediately after the edge on which count wrapped; the first tick after reset arrives N enabled edges after reset release.

Reset
REQ-026 While reset=1, asynchronously:
- count=0, tick=0, clk_out=0, ticks=0, ratio_err=0.
- shadow = N_active = DEFAULT_DIV.
REQ-027 Reset asserted mid-period SHALL abort the period immediately; no tick SHALL be produced for it.

Verification
REQ-028 Reset, enable=1 for 300 edges (DEFAULT_DIV=100) -> tick pulses after edges 100, 200, 300; clk_out high in counts 50..99; ticks=3.
REQ-029 Load 10 at count=40 of a 100-period -> current period still 100 edges; following periods 10 edges with clk_out 5 low / 5 high.
REQ-030 Load 0 -> shadow unchanged, ratio_err=1 and still 1 after 500 edges; reset -> ratio_err=0.
REQ-031 enable=0 for 20 edges at count=30 -> count stays 30, tick=0; after re-enable the wrap occurs 70 edges later.
REQ-032 Clear and load 3 on the same edge at count=77 -> count=0; periods of 3 follow with clk_out pattern 0,1,1; ticks not incremented.
REQ-033 Load 1, then ticks near 255 with TICKS_WIDTH=8 -> tick high every cycle; ticks wraps 255 -> 0; clk_out constantly 1.
